// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline hazard/forwarding controller.
package pipe_ctrl_pkg;

    // Write-data select encodings
    localparam logic [1:0] WDSEL_ALU = 2'b00;
    localparam logic [1:0] WDSEL_MEM = 2'b01;
    localparam logic [1:0] WDSEL_PC  = 2'b10;

    // EX operand source encodings
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Control carried through EX and MEM
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic [4:0] rd;
        logic [1:0] wd_sel;
    } stage_ctrl_t;

    // Control carried into WB (no memory write left to perform)
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [4:0] rd;
        logic [1:0] wd_sel;
    } wb_ctrl_t;

    // True when a producer index matches a consumer index and is not x0
    function automatic logic reg_match(input logic [4:0] prod, input logic [4:0] cons);
        return (prod == cons) && (prod != 5'd0);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Forwarding selector for one EX operand; MEM result beats WB write data.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic       mem_valid,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_rd,
    input  logic [1:0] mem_wd_sel,
    input  logic       wb_valid,
    input  logic       wb_reg_write,
    input  logic [4:0] wb_rd,
    output logic [1:0] fwd
);

    // Pick the youngest producer; a load still in MEM has no data yet
    always_comb begin
        fwd = FWD_RF;
        if (mem_valid && mem_reg_write && (mem_wd_sel != WDSEL_MEM) && reg_match(mem_rd, ex_rs)) begin
            fwd = FWD_EXMEM;
        end else if (wb_valid && wb_reg_write && reg_match(wb_rd, ex_rs)) begin
            fwd = FWD_MEMWB;
        end else begin
            fwd = FWD_RF;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: stage control registers, load-use stall, redirect flush,
// operand forwarding and saturating stall/flush event counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_RegWrite,
    input  logic             id_MemWrite,
    input  logic [1:0]       id_WDSel,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             ex_valid,
    output logic             ex_RegWrite,
    output logic             ex_MemWrite,
    output logic [4:0]       ex_rd,
    output logic [1:0]       ex_WDSel,
    output logic             mem_valid,
    output logic             mem_RegWrite,
    output logic             mem_MemWrite,
    output logic [4:0]       mem_rd,
    output logic [1:0]       mem_WDSel,
    output logic             wb_valid,
    output logic             wb_RegWrite,
    output logic [4:0]       wb_rd,
    output logic [1:0]       wb_WDSel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    stage_ctrl_t      ex_r;
    stage_ctrl_t      mem_r;
    wb_ctrl_t         wb_r;
    stage_ctrl_t      id_ctrl_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic             load_use_s;
    logic             stall_evt_s;
    logic             flush_evt_s;

    assign id_ctrl_s = '{valid: id_valid, reg_write: id_RegWrite, mem_write: id_MemWrite,
                         rd: id_rd, wd_sel: id_WDSel};

    // Load in EX whose destination the ID instruction actually reads
    assign load_use_s = id_valid && ex_r.valid && ex_r.reg_write && (ex_r.wd_sel == WDSEL_MEM) &&
                        ((id_use_rs1 && reg_match(ex_r.rd, id_rs1)) ||
                         (id_use_rs2 && reg_match(ex_r.rd, id_rs2)));

    // Redirect wins over load-use; nothing counts while memory is busy
    assign flush_evt_s = ex_redirect && !mem_busy;
    assign stall_evt_s = load_use_s && !ex_redirect && !mem_busy;

    // Front-end enables: reset > busy freeze > redirect flush > load-use stall > run
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (rst) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else if (ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use_s) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            pc_we = 1'b1;
        end
    end

    // Advance ID->EX->MEM->WB unless memory holds the pipe; bubble loads an empty EX
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_r  <= '0;
            mem_r <= '0;
            wb_r  <= '0;
        end else if (mem_busy) begin
            ex_r  <= ex_r;
            mem_r <= mem_r;
            wb_r  <= wb_r;
        end else begin
            ex_r  <= idex_bubble ? stage_ctrl_t'('0) : id_ctrl_s;
            mem_r <= ex_r;
            wb_r  <= '{valid: mem_r.valid, reg_write: mem_r.reg_write, rd: mem_r.rd, wd_sel: mem_r.wd_sel};
        end
    end

    // Saturating counters of stall cycles and redirect flush cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (stall_evt_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_evt_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    fwd_unit u_fwd_a (
        .ex_rs(ex_rs1), .mem_valid(mem_r.valid), .mem_reg_write(mem_r.reg_write),
        .mem_rd(mem_r.rd), .mem_wd_sel(mem_r.wd_sel), .wb_valid(wb_r.valid),
        .wb_reg_write(wb_r.reg_write), .wb_rd(wb_r.rd), .fwd(fwd_a)
    );

    fwd_unit u_fwd_b (
        .ex_rs(ex_rs2), .mem_valid(mem_r.valid), .mem_reg_write(mem_r.reg_write),
        .mem_rd(mem_r.rd), .mem_wd_sel(mem_r.wd_sel), .wb_valid(wb_r.valid),
        .wb_reg_write(wb_r.reg_write), .wb_rd(wb_r.rd), .fwd(fwd_b)
    );

    assign ex_valid     = ex_r.valid;
    assign ex_RegWrite  = ex_r.reg_write;
    assign ex_MemWrite  = ex_r.mem_write;
    assign ex_rd        = ex_r.rd;
    assign ex_WDSel     = ex_r.wd_sel;
    assign mem_valid    = mem_r.valid;
    assign mem_RegWrite = mem_r.reg_write;
    assign mem_MemWrite = mem_r.mem_write;
    assign mem_rd       = mem_r.rd;
    assign mem_WDSel    = mem_r.wd_sel;
    assign wb_valid     = wb_r.valid;
    assign wb_RegWrite  = wb_r.reg_write;
    assign wb_rd        = wb_r.rd;
    assign wb_WDSel     = wb_r.wd_sel;
    assign stall_cnt    = stall_cnt_r;
    assign flush_cnt    = flush_cnt_r;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the stall and flush performance counters.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have ports id_valid, id_RegWrite, id_MemWrite, input, 1 each: ID-stage instruction valid, register write, memory write.
REQ-005 SHALL have port id_WDSel, input, 2: write-data select; 00 ALU, 01 MEM, 10 PC.
REQ-006 SHALL have ports id_rs1, id_rs2, id_rd, input, 5 each: ID-stage register indices.
REQ-007 SHALL have ports id_use_rs1, id_use_rs2, input, 1 each: ID instruction actually reads rs1 or rs2.
REQ-008 SHALL have ports ex_rs1, ex_rs2, input, 5 each: source indices of the instruction currently in EX.
REQ-009 SHALL have port ex_redirect, input, 1: EX resolved a taken branch, jal or jalr.
REQ-010 SHALL have port mem_busy, input, 1: data memory needs another cycle.
REQ-011 SHALL have ports pc_we, ifid_we, output, 1 each: PC and IF/ID register write enables.
REQ-012 SHALL have ports ifid_flush, idex_bubble, output, 1 each: clear IF/ID; insert NOP into ID/EX.
REQ-013 SHALL have ports fwd_a, fwd_b, output, 2 each: EX operand source; 00 regfile, 01 EX/MEM result, 10 MEM/WB write data.
REQ-014 SHALL have ports ex_/mem_/wb_{valid,RegWrite,rd,WDSel} and ex_/mem_MemWrite, output: registered control per stage.
REQ-015 SHALL have ports stall_cnt, flush_cnt, output, CNT_W each: saturating event counters.

Function
REQ-016 SHALL advance ID->EX->MEM->WB control registers every cycle in which mem_busy=0.
REQ-017 SHALL freeze all stage registers and drive pc_we=0, ifid_we=0, idex_bubble=0 and ifid_flush=0 while mem_busy=1.
REQ-018 SHALL detect load-use when ex_valid & ex_RegWrite & ex_WDSel=01 & ex_rd!=0 & ((id_use_rs1 & id_rs1=ex_rd) | (id_use_rs2 & id_rs2=ex_rd)) & id_valid.
REQ-019 SHALL, on load-use with no redirect and mem_busy=0, drive pc_we=0, ifid_we=0, idex_bubble=1 for exactly one cycle.
REQ-020 SHALL, on ex_redirect=1 with mem_busy=0, drive ifid_flush=1 and idex_bubble=1 for one cycle, keeping pc_we=1.
REQ-021 SHALL give ex_redirect priority over load-use; both true gives flush only, no stall, stall_cnt unchanged.
REQ-022 SHALL make a bubble load ex_valid=0 with RegWrite, MemWrite and WDSel all zero.
REQ-023 SHALL set fwd_a=01 when mem_valid & mem_RegWrite & mem_rd!=0 & mem_rd=ex_rs1 & mem_WDSel!=01.
REQ-024 SHALL otherwise set fwd_a=10 when wb_valid & wb_RegWrite & wb_rd!=0 & wb_rd=ex_rs1, else 00; fwd_b identically on ex_rs2.
REQ-025 SHALL never forward register x0; MEM-stage match SHALL override WB-stage match.
REQ-026 SHALL compute forwarding and hazard outputs combinationally from current state and inputs, zero-cycle latency.
REQ-027 SHALL increment stall_cnt per load-use stall cycle and flush_cnt per redirect cycle, each holding at all-ones.
REQ-028 SHALL default to pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0 when no stall, flush or busy is active.

Reset
REQ-029 SHALL on rst=1 at a clock edge clear every stage valid, RegWrite, MemWrite, rd and WDSel, plus both counters.
REQ-030 SHALL let rst override mem_busy, stall and flush, including mid-stall or mid-busy.
REQ-031 SHALL, during rst=1, drive pc_we=1, ifid_we=1, ifid_flush=1 and idex_bubble=1.

Structure
REQ-032 SHALL place WDSel encodings (ALU/MEM/PC) and forward encodings (RF/EXMEM/MEMWB) in shared package pipe_ctrl_pkg.
REQ-033 SHALL implement forwarding selection in one combinational sub-module, fwd_unit, instantiated once per operand.

Verification
REQ-034 SHALL cover load-use: EX lw x5 then ID add x6,x5,x7 -> one cycle of pc_we=0, idex_bubble=1; next cycle fwd_a=10; stall_cnt=1.
REQ-035 SHALL cover back-to-back ALU: MEM add x3, EX sub x4,x3,x3 -> fwd_a=01, fwd_b=01.
REQ-036 SHALL cover double hazard: MEM and WB both write x9, EX reads x9 -> fwd_a=01; a write to x0 -> fwd_a=00.
REQ-037 SHALL cover redirect plus load-use in the same cycle -> ifid_flush=1, idex_bubble=1, pc_we=1, stall_cnt unchanged, flush_cnt+1.
REQ-038 SHALL cover mem_busy held 3 cycles during a redirect -> stages frozen 3 cycles, then flush issued exactly once.
REQ-039 SHALL cover rst asserted mid-stall -> next cycle all valids 0, counters 0, pc_we=1.
